csr_trap_unit: RTL and testbench
================================

# csr_trap_unit

Parametrised machine-mode CSR file with trap sequencing for the RISC-V core. It extends the basic CSR register set with the CSR read-modify-write operations, platform-local interrupt lines, interrupt prioritisation, and trap entry and `mret`. It also provides vectored `mtvec` and optional 64-bit performance counters. It sits beside the decode/execute stage: the core presents CSR instructions, exceptions and retire pulses, and the unit returns read data, trap target PC and interrupt requests.

## Interface
- `NUM_LOCAL_IRQ`, 4: platform interrupt lines mapped to `mip`/`mie` bits [16 +: N]; legal 0–16.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`; bits [1:0] must be 00 or 01.
- `HART_ID`, 0: value returned by `mhartid` (0xF14).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `csr_en`  in  1  a CSR instruction is valid this cycle.
- `csr_op`  in  2  00 read-only, 01 RW, 10 RS (set), 11 RC (clear).
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  operand (rs1 value or zimm).
- `csr_rdata`  out  32  current (pre-write) CSR value.
- `csr_illegal`  out  1  unknown address, or write op to a read-only CSR.
- `irq_software`, `irq_timer`, `irq_external`  in  1 each  level interrupt inputs.
- `irq_local`  in  NUM_LOCAL_IRQ  level platform interrupts.
- `exc_valid`  in  1  synchronous exception this cycle.
- `exc_code`  in  5  exception cause code.
- `exc_tval`  in  32  value for `mtval`.
- `trap_pc`  in  32  PC of the trapping or interrupted instruction.
- `trap_enter`  in  1  core commits a trap this cycle: exception if `exc_valid`, else `irq_cause`.
- `mret`  in  1  core executes `mret`.
- `instret`  in  1  one instruction retired.
- `irq_req`  out  1  an enabled interrupt is pending and `mstatus.MIE` is 1.
- `irq_cause`  out  32  mcause value of the highest-priority pending interrupt, with bit31 set.
- `trap_vector`  out  32  target PC for `trap_enter`.
- `mret_pc`  out  32  current `mepc`.
- `mstatus_mie`  out  1  global interrupt enable.

## Operation
- CSRs: `mstatus` 0x300, `misa` 0x301 (read-only, RV32I), `mie` 0x304, `mtvec` 0x305, `mscratch` 0x340, `mepc` 0x341, `mcause` 0x342, `mtval` 0x343, `mip` 0x344 (read-only), `mhartid` 0xF14 (read-only).
- Write value by op:
  - RW: `wdata`.
  - RS: `old | wdata`.
  - RC: `old & ~wdata`.
  - Op 00 never writes.
- Read-only rule: a write op to a read-only CSR, or to any address with [11:10]=11, asserts `csr_illegal` and performs no write.
- Unknown addresses assert `csr_illegal` and read 0.
- WARL fields:
  - `mstatus`: only MIE(3) and MPIE(7) are writable; MPP(12:11) is hardwired to 11.
  - `mie`: writable bits are 3, 7, 11 and [16 +: N]; all other bits read 0.
  - `mtvec`: a written MODE of 10 or 11 stores 00.
  - `mepc[1:0]` always reads 0.
- `mip` is live: bit3 = `irq_software`, bit7 = `irq_timer`, bit11 = `irq_external`, bits [16 +: N] = `irq_local`.
- Interrupt priority, highest first: MEI(11) > MSI(3) > MTI(7) > local lowest index first. Only bits set in `mip & mie` are considered.
- Trap entry on `trap_enter`:
  - `mepc` ← `trap_pc` & ~3.
  - `mcause` ← {0, exc_code} if `exc_valid`, else `irq_cause`.
  - `mtval` ← `exc_tval` for an exception, 0 for an interrupt.
  - `MPIE` ← `MIE`, then `MIE` ← 0.
- `trap_vector`: `mtvec` BASE if MODE=00 or the trap is an exception; BASE + 4·cause[4:0] if MODE=01 and the trap is an interrupt.
- `mret`: `MIE` ← `MPIE`, `MPIE` ← 1.
- Simultaneous events:
  - `trap_enter` beats `mret` and beats a CSR write in the same cycle; the losing updates are dropped.
  - `exc_valid` beats a pending interrupt.

## Timing
- `csr_rdata`, `csr_illegal`, `irq_req`, `irq_cause` and `trap_vector` are combinational from the current state and inputs.
- All CSR writes, trap entry and `mret` updates take effect at the rising edge, visible the next cycle.
- Interrupt inputs are assumed already synchronous to `clock`.
- Reset values:
  - `mstatus` = 0x0000_1800.
  - `mie`, `mepc`, `mcause`, `mtval`, `mscratch` = 0.
  - `mtvec` = `MTVEC_RESET`.
  - Counters = 0.
- Outputs in reset: `irq_req` = 0, `mstatus_mie` = 0, `mret_pc` = 0, `trap_vector` = `MTVEC_RESET` & ~3.
- Reset asserted mid-operation aborts any update in the same cycle.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - 64-bit `mcycle` (0xB00/0xB80) increments every cycle; 64-bit `minstret` (0xB02/0xB82) increments on `instret`.
  - Both wrap at 2^64. Read-only aliases `cycle`/`instret` are at 0xC00/0xC80/0xC02/0xC82.
  - A write to either half replaces that half and suppresses that counter's increment for the cycle.
- Undefined: no counter registers exist; all eight addresses read 0, are not illegal, and writes are ignored.

## Structure
- Package `csr_pkg`: CSR address constants, `csr_op_t` enum, interrupt and exception cause constants, `mstatus` bit indices.
- Sub-module `csr_irq_arbiter`: combinational priority encoder over `mip & mie`, producing `irq_req` and `irq_cause`.

## Test plan
- Reset → `mstatus` reads 0x1800, `mtvec` reads `MTVEC_RESET`, `irq_req` = 0.
- `mscratch` RW 0xA5A5_0000, then RS 0x0000_00FF, then RC 0xA500_0000 → reads 0x00A5_00FF; `csr_illegal` stays 0.
- RW to 0xF14 → `csr_illegal` = 1, value remains `HART_ID`; read of 0x7FF → 0 with `csr_illegal` = 1.
- `mie` = 0x880, `MIE` = 1, `mtvec` = 0x100 | 1, `irq_timer` and `irq_external` both high → `irq_cause` = 0x8000_000B, `trap_vector` = 0x12C. After `trap_enter` with `trap_pc` = 0x40: `mepc` = 0x40, `MIE` = 0, `MPIE` = 1. `mret` → `MIE` = 1.
- `exc_valid` with code 2, `exc_tval` = 0xDEAD, plus a pending interrupt and a CSR write, all with `trap_enter` → `mcause` = 2, `mtval` = 0xDEAD, `trap_vector` = BASE, CSR write dropped.
- With `CSR_COUNTERS_EN`: write `mcycle` low = 0xFFFF_FFFF → two cycles later low = 0x0000_0000 and high incremented by 1 (1 cycle write, 1 increment carries).

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file and trap unit.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  localparam int IRQ_MSI        = 3;
  localparam int IRQ_MTI        = 7;
  localparam int IRQ_MEI        = 11;
  localparam int IRQ_LOCAL_BASE = 16;

  function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_value,
                                            logic [31:0] operand);
    case (op)
      CSR_OP_RW: return operand;
      CSR_OP_RS: return old_value | operand;
      CSR_OP_RC: return old_value & ~operand;
      default:   return old_value;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR instruction bus between the execute stage (master) and the CSR unit (slave).
interface csr_trap_unit_if;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (output csr_en, csr_op, csr_addr, csr_wdata,
                  input  csr_rdata, csr_illegal);
  modport slave  (input  csr_en, csr_op, csr_addr, csr_wdata,
                  output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > local lines, lowest index first.
module csr_irq_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic        msi,
  input  logic        mti,
  input  logic        mei,
  input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] local_pending,
  input  logic        global_mie,
  output logic        irq_req,
  output logic [31:0] irq_cause
);

  logic any_pending;

  // Lowest-priority candidates are assigned first so higher ones overwrite them.
  always_comb begin
    any_pending = 1'b0;
    irq_cause   = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (local_pending[i]) begin
        any_pending = 1'b1;
        irq_cause   = 32'h8000_0000 | 32'(IRQ_LOCAL_BASE + i);
      end
    end
    if (mti) begin
      any_pending = 1'b1;
      irq_cause   = 32'h8000_0000 | 32'(IRQ_MTI);
    end
    if (msi) begin
      any_pending = 1'b1;
      irq_cause   = 32'h8000_0000 | 32'(IRQ_MSI);
    end
    if (mei) begin
      any_pending = 1'b1;
      irq_cause   = 32'h8000_0000 | 32'(IRQ_MEI);
    end
  end

  assign irq_req = any_pending && global_mie;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt arbitration, trap entry and mret.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  csr_trap_unit_if.slave bus,
  input  logic        irq_software,
  input  logic        irq_timer,
  input  logic        irq_external,
  input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic [31:0] trap_pc,
  input  logic        trap_enter,
  input  logic        mret,
  input  logic        instret,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] mret_pc,
  output logic        mstatus_mie
);

  localparam int LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;
  localparam logic [31:0] MIE_MASK =
    32'h0000_0888 | (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << IRQ_LOCAL_BASE);

  logic        status_mie_reg, status_mpie_reg;
  logic [31:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [31:0] mip, mstatus_value, csr_rdata, csr_wval, mtvec_base;
  logic        known, read_only, is_write, csr_illegal, csr_we;
  csr_op_t     op;

  always_comb begin
    mip = '0;
    mip[IRQ_MSI] = irq_software;
    mip[IRQ_MTI] = irq_timer;
    mip[IRQ_MEI] = irq_external;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip[IRQ_LOCAL_BASE + i] = irq_local[i];
  end

  csr_irq_arbiter #(.NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)) u_arbiter (
    .msi           (irq_software & mie_reg[IRQ_MSI]),
    .mti           (irq_timer & mie_reg[IRQ_MTI]),
    .mei           (irq_external & mie_reg[IRQ_MEI]),
    .local_pending (irq_local & mie_reg[IRQ_LOCAL_BASE +: LW]),
    .global_mie    (status_mie_reg),
    .irq_req       (irq_req),
    .irq_cause     (irq_cause)
  );

  assign mstatus_value = MSTATUS_MPP_M | (32'(status_mpie_reg) << MSTATUS_MPIE)
                                       | (32'(status_mie_reg) << MSTATUS_MIE);

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_reg, minstret_reg;
`else
  logic unused_instret;
  assign unused_instret = instret;
`endif

  always_comb begin
    csr_rdata = '0;
    known     = 1'b1;
    read_only = (bus.csr_addr[11:10] == 2'b11);
    case (bus.csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_value;
      CSR_MISA:     begin csr_rdata = MISA_VALUE; read_only = 1'b1; end
      CSR_MIE:      csr_rdata = mie_reg;
      CSR_MTVEC:    csr_rdata = mtvec_reg;
      CSR_MSCRATCH: csr_rdata = mscratch_reg;
      CSR_MEPC:     csr_rdata = mepc_reg;
      CSR_MCAUSE:   csr_rdata = mcause_reg;
      CSR_MTVAL:    csr_rdata = mtval_reg;
      CSR_MIP:      begin csr_rdata = mip; read_only = 1'b1; end
      CSR_MHARTID:  begin csr_rdata = HART_ID; read_only = 1'b1; end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = mcycle_reg[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = mcycle_reg[63:32];
      CSR_MINSTRET, CSR_INSTRET:  csr_rdata = minstret_reg[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret_reg[63:32];
`else
      // Counter addresses are decoded so software probing them sees zero, not a trap.
      CSR_MCYCLE, CSR_CYCLE, CSR_MCYCLEH, CSR_CYCLEH,
      CSR_MINSTRET, CSR_INSTRET, CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = '0;
`endif
      default:      known = 1'b0;
    endcase
  end

  assign op          = csr_op_t'(bus.csr_op);
  assign is_write    = (op != CSR_OP_READ);
  assign csr_illegal = bus.csr_en && (!known || (is_write && read_only));
  assign csr_we      = bus.csr_en && is_write && !csr_illegal && !trap_enter;
  assign csr_wval    = csr_apply(op, csr_rdata, bus.csr_wdata);

  assign bus.csr_rdata   = csr_rdata;
  assign bus.csr_illegal = csr_illegal;

  assign mtvec_base  = {mtvec_reg[31:2], 2'b00};
  assign trap_vector = (mtvec_reg[1:0] == 2'b01 && !exc_valid)
                     ? mtvec_base + {25'b0, irq_cause[4:0], 2'b00} : mtvec_base;
  assign mret_pc     = mepc_reg;
  assign mstatus_mie = status_mie_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_mie_reg  <= 1'b0;
      status_mpie_reg <= 1'b0;
      mie_reg         <= '0;
      mtvec_reg       <= MTVEC_RESET;
      mscratch_reg    <= '0;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
      mtval_reg       <= '0;
    end else if (trap_enter) begin
      mepc_reg        <= trap_pc & ~32'h3;
      mcause_reg      <= exc_valid ? {27'b0, exc_code} : irq_cause;
      mtval_reg       <= exc_valid ? exc_tval : '0;
      status_mpie_reg <= status_mie_reg;
      status_mie_reg  <= 1'b0;
    end else begin
      if (csr_we) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            status_mie_reg  <= csr_wval[MSTATUS_MIE];
            status_mpie_reg <= csr_wval[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_reg      <= csr_wval & MIE_MASK;
          CSR_MTVEC:    mtvec_reg    <= {csr_wval[31:2], csr_wval[1] ? 2'b00 : csr_wval[1:0]};
          CSR_MSCRATCH: mscratch_reg <= csr_wval;
          CSR_MEPC:     mepc_reg     <= csr_wval & ~32'h3;
          CSR_MCAUSE:   mcause_reg   <= csr_wval;
          CSR_MTVAL:    mtval_reg    <= csr_wval;
          default: ;
        endcase
      end
      // mret is evaluated after the CSR write so it wins on MIE/MPIE.
      if (mret) begin
        status_mie_reg  <= status_mpie_reg;
        status_mpie_reg <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcycle_reg   <= '0;
      minstret_reg <= '0;
    end else begin
      if (csr_we && bus.csr_addr == CSR_MCYCLE)       mcycle_reg[31:0]  <= csr_wval;
      else if (csr_we && bus.csr_addr == CSR_MCYCLEH) mcycle_reg[63:32] <= csr_wval;
      else                                            mcycle_reg <= mcycle_reg + 64'd1;

      if (csr_we && bus.csr_addr == CSR_MINSTRET)       minstret_reg[31:0]  <= csr_wval;
      else if (csr_we && bus.csr_addr == CSR_MINSTRETH) minstret_reg[63:32] <= csr_wval;
      else if (instret)                                 minstret_reg <= minstret_reg + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: stimulus queues expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_csr_trap_unit;

  localparam int          N         = 4;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0201;
  localparam logic [31:0] HART      = 32'h0000_0005;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        irq_software = 1'b0, irq_timer = 1'b0, irq_external = 1'b0;
  logic [N-1:0] irq_local = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_tval = '0, trap_pc = '0;
  logic        trap_enter = 1'b0, mret = 1'b0, instret = 1'b0;
  logic        irq_req, mstatus_mie;
  logic [31:0] irq_cause, trap_vector, mret_pc;

  csr_trap_unit_if bus();

  always #5 clock = ~clock;

  csr_trap_unit #(.NUM_LOCAL_IRQ(N), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .irq_software (irq_software),
    .irq_timer    (irq_timer),
    .irq_external (irq_external),
    .irq_local    (irq_local),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_tval     (exc_tval),
    .trap_pc      (trap_pc),
    .trap_enter   (trap_enter),
    .mret         (mret),
    .instret      (instret),
    .irq_req      (irq_req),
    .irq_cause    (irq_cause),
    .trap_vector  (trap_vector),
    .mret_pc      (mret_pc),
    .mstatus_mie  (mstatus_mie)
  );

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rdata;
    logic        illegal;
    bit          aux;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [31:0] vec;
    logic        mie;
    logic [31:0] mpc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%08h required=%08h", name, field, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (bus.csr_en === 1'b1) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn actual=transaction required=none addr=%03h", bus.csr_addr);
      end else begin
        e = sb_q.pop_front();
        $display("txn %-16s op=%0d addr=%03h wdata=%08h rdata=%08h illegal=%b",
                 e.name, bus.csr_op, bus.csr_addr, bus.csr_wdata, bus.csr_rdata, bus.csr_illegal);
        if (e.chk_rd) cmp(e.name, "rdata", bus.csr_rdata, e.rdata);
        cmp(e.name, "illegal", 32'(bus.csr_illegal), 32'(e.illegal));
        if (e.aux) begin
          cmp(e.name, "irq_req", 32'(irq_req), 32'(e.irq_req));
          cmp(e.name, "irq_cause", irq_cause, e.irq_cause);
          cmp(e.name, "trap_vector", trap_vector, e.vec);
          cmp(e.name, "mstatus_mie", 32'(mstatus_mie), 32'(e.mie));
          cmp(e.name, "mret_pc", mret_pc, e.mpc);
        end
      end
    end
  end

  task automatic txn(string name, logic [1:0] op, logic [11:0] addr, logic [31:0] wdata,
                     bit chk_rd, logic [31:0] rdata, logic ill, bit aux,
                     logic a_req, logic [31:0] a_cause, logic [31:0] a_vec,
                     logic a_mie, logic [31:0] a_mpc);
    exp_t e;
    e.name = name; e.chk_rd = chk_rd; e.rdata = rdata; e.illegal = ill; e.aux = aux;
    e.irq_req = a_req; e.irq_cause = a_cause; e.vec = a_vec; e.mie = a_mie; e.mpc = a_mpc;
    sb_q.push_back(e);
    bus.csr_en = 1'b1; bus.csr_op = op; bus.csr_addr = addr; bus.csr_wdata = wdata;
    @(posedge clock);
    #1;
    bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_wdata = '0;
  endtask

  task automatic rd(string name, logic [11:0] addr, logic [31:0] rdata, logic ill);
    txn(name, 2'b00, addr, 32'h0, 1'b1, rdata, ill, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wr(string name, logic [1:0] op, logic [11:0] addr, logic [31:0] wdata,
                    logic [31:0] rdata, logic ill);
    txn(name, op, addr, wdata, 1'b1, rdata, ill, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rd_aux(string name, logic [11:0] addr, logic [31:0] rdata, logic a_req,
                        logic [31:0] a_cause, logic [31:0] a_vec, logic a_mie,
                        logic [31:0] a_mpc);
    txn(name, 2'b00, addr, 32'h0, 1'b1, rdata, 1'b0, 1'b1, a_req, a_cause, a_vec, a_mie, a_mpc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = '0; bus.csr_wdata = '0;
    @(posedge clock);
    #1;
    rd_aux("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0, 32'h0, 32'h200, 1'b0, 32'h0);
    rd("rst_mtvec", 12'h305, MTVEC_RST, 1'b0);
    reset = 1'b0;

    wr("scratch_rw", 2'b01, 12'h340, 32'hA5A5_0000, 32'h0, 1'b0);
    wr("scratch_rs", 2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0);
    wr("scratch_rc", 2'b11, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0);
    rd("scratch_rd", 12'h340, 32'h00A5_00FF, 1'b0);
    wr("hartid_wr", 2'b01, 12'hF14, 32'h123, HART, 1'b1);
    rd("hartid_rd", 12'hF14, HART, 1'b0);
    rd("unknown_rd", 12'h7FF, 32'h0, 1'b1);
    rd("misa_rd", 12'h301, 32'h4000_0100, 1'b0);
    wr("misa_wr", 2'b01, 12'h301, 32'h0, 32'h4000_0100, 1'b1);
    wr("mip_wr", 2'b10, 12'h344, 32'h1, 32'h0, 1'b1);
    wr("mie_all", 2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
    rd("mie_warl", 12'h304, 32'h000F_0888, 1'b0);
    wr("mie_880", 2'b01, 12'h304, 32'h0000_0880, 32'h000F_0888, 1'b0);
    wr("mtvec_mode3", 2'b01, 12'h305, 32'h0000_0103, MTVEC_RST, 1'b0);
    rd("mtvec_warl", 12'h305, 32'h0000_0100, 1'b0);
    wr("mtvec_vect", 2'b01, 12'h305, 32'h0000_0101, 32'h0000_0100, 1'b0);
    wr("mtval_wr", 2'b01, 12'h343, 32'h0000_0077, 32'h0, 1'b0);
    wr("mie_set", 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0);
    rd("mstatus_mie1", 12'h300, 32'h0000_1808, 1'b0);

    // Timer and external both pending: external wins, vectored target.
    irq_timer = 1'b1; irq_external = 1'b1;
    rd_aux("irq_mei", 12'h344, 32'h0000_0880, 1'b1, 32'h8000_000B, 32'h0000_012C, 1'b1, 32'h0);
    trap_enter = 1'b1; trap_pc = 32'h0000_0043;
    rd_aux("irq_trap", 12'h344, 32'h0000_0880, 1'b1, 32'h8000_000B, 32'h0000_012C, 1'b1, 32'h0);
    trap_enter = 1'b0; trap_pc = '0;
    rd_aux("trap_mepc", 12'h341, 32'h0000_0040, 1'b0, 32'h8000_000B, 32'h0000_012C, 1'b0, 32'h40);
    rd("trap_mstatus", 12'h300, 32'h0000_1880, 1'b0);
    rd("trap_mcause", 12'h342, 32'h8000_000B, 1'b0);
    rd("trap_mtval", 12'h343, 32'h0, 1'b0);
    mret = 1'b1;
    rd("mret_cycle", 12'h300, 32'h0000_1880, 1'b0);
    mret = 1'b0;
    rd_aux("mret_after", 12'h300, 32'h0000_1888, 1'b1, 32'h8000_000B, 32'h0000_012C, 1'b1, 32'h40);

    // Exception beats pending interrupt and a same-cycle CSR write.
    exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'h0000_DEAD;
    trap_enter = 1'b1; trap_pc = 32'h0000_0080;
    txn("exc_trap", 2'b01, 12'h340, 32'h0000_1234, 1'b1, 32'h00A5_00FF, 1'b0, 1'b1,
        1'b1, 32'h8000_000B, 32'h0000_0100, 1'b1, 32'h40);
    exc_valid = 1'b0; exc_code = '0; exc_tval = '0; trap_enter = 1'b0; trap_pc = '0;
    rd("exc_scratch", 12'h340, 32'h00A5_00FF, 1'b0);
    rd("exc_mcause", 12'h342, 32'h0000_0002, 1'b0);
    rd("exc_mtval", 12'h343, 32'h0000_DEAD, 1'b0);
    rd("exc_mepc", 12'h341, 32'h0000_0080, 1'b0);
    rd("exc_mstatus", 12'h300, 32'h0000_1880, 1'b0);

    // Local lines 1 and 2 pending: index 1 (cause 17) wins.
    irq_timer = 1'b0; irq_external = 1'b0; irq_local = 4'b0110;
    wr("mie_local", 2'b01, 12'h304, 32'h0006_0000, 32'h0000_0880, 1'b0);
    rd_aux("irq_local_off", 12'h344, 32'h0006_0000, 1'b0, 32'h8000_0011, 32'h0000_0144, 1'b0, 32'h80);
    wr("mie_set2", 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b0);
    rd_aux("irq_local_on", 12'h344, 32'h0006_0000, 1'b1, 32'h8000_0011, 32'h0000_0144, 1'b1, 32'h80);
    irq_software = 1'b1; irq_timer = 1'b1;
    wr("mie_msi_mti", 2'b01, 12'h304, 32'h0000_0088, 32'h0006_0000, 1'b0);
    rd_aux("irq_msi", 12'h344, 32'h0006_0088, 1'b1, 32'h8000_0003, 32'h0000_010C, 1'b1, 32'h80);
    irq_software = 1'b0; irq_timer = 1'b0; irq_local = '0;
    wr("mtvec_mode2", 2'b01, 12'h305, 32'h0000_0202, 32'h0000_0101, 1'b0);
    rd_aux("mtvec_direct", 12'h305, 32'h0000_0200, 1'b0, 32'h0, 32'h0000_0200, 1'b1, 32'h80);

`ifdef CSR_COUNTERS_EN
    txn("mcycleh_wr", 2'b01, 12'hB80, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0,
        1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    txn("mcycle_wr", 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0,
        1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rd("mcycle_lo", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    rd("mcycle_carry", 12'hB80, 32'h0000_0011, 1'b0);
    rd("mcycle_inc", 12'hB00, 32'h0000_0001, 1'b0);
    rd("cycleh_alias", 12'hC80, 32'h0000_0011, 1'b0);
    wr("minstret_wr", 2'b01, 12'hB02, 32'h0000_0005, 32'h0, 1'b0);
    instret = 1'b1;
    rd("minstret_rd", 12'hB02, 32'h0000_0005, 1'b0);
    instret = 1'b0;
    rd("instret_alias", 12'hC02, 32'h0000_0006, 1'b0);
    wr("instret_wr", 2'b01, 12'hC02, 32'h0, 32'h0000_0006, 1'b1);
`else
    rd("mcycle_absent", 12'hB00, 32'h0, 1'b0);
    wr("mcycleh_wr", 2'b01, 12'hB80, 32'h1, 32'h0, 1'b0);
    rd("mcycleh_rd", 12'hB80, 32'h0, 1'b0);
    instret = 1'b1;
    rd("minstret_rd", 12'hB02, 32'h0, 1'b0);
    instret = 1'b0;
    wr("cycle_wr", 2'b01, 12'hC00, 32'h1, 32'h0, 1'b1);
`endif

    // Reset asserted during a write aborts it and restores reset values.
    reset = 1'b1;
    wr("rst_during_wr", 2'b01, 12'h340, 32'h0000_0099, 32'h0, 1'b0);
    reset = 1'b0;
    rd("rst_scratch", 12'h340, 32'h0, 1'b0);
    rd("rst_mtvec2", 12'h305, MTVEC_RST, 1'b0);
    rd_aux("rst_mstatus2", 12'h300, 32'h0000_1800, 1'b0, 32'h0, 32'h0000_0200, 1'b0, 32'h0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clock);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
